alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/core_pkg.sv | 26 ++
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: ALU opcodes and the ALU arbiter state encoding.
// Imported by every block that talks to the ALU.
package core_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLTS = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_MUL  = 4'd10
   } alu_opcode_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

endpackage

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU with a
// one-entry response slot; 1 op/cycle when the owner keeps draining.
module alu_arbiter
   import core_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid_ip,
   output logic            req0_ready_op,
   input  alu_opcode_e     req0_operator_ip,
   input  logic [XLEN-1:0] req0_operand_a_ip,
   input  logic [XLEN-1:0] req0_operand_b_ip,
   input  logic            req1_valid_ip,
   output logic            req1_ready_op,
   input  alu_opcode_e     req1_operator_ip,
   input  logic [XLEN-1:0] req1_operand_a_ip,
   input  logic [XLEN-1:0] req1_operand_b_ip,
   output logic            rsp0_valid_op,
   input  logic            rsp0_ready_ip,
   output logic            rsp1_valid_op,
   input  logic            rsp1_ready_ip,
   output logic [XLEN-1:0] rsp_result_op,
   output logic            rsp_error_op,
   output logic            alu_enable_op,
   output alu_opcode_e     alu_operator_op,
   output logic [XLEN-1:0] alu_operand_a_op,
   output logic [XLEN-1:0] alu_operand_b_op,
   input  logic [XLEN-1:0] alu_result_ip,
   input  logic            alu_valid_ip
);

   arb_state_e      state_q;
   arb_state_e      state_d;
   logic            owner_q;
   logic            prio_q;
   logic [XLEN-1:0] result_q;
   logic            error_q;

   logic            own_ready;
   logic            slot_free;
   logic            grant;
   logic            gnt_id;

   // The slot frees up in the same cycle the owner drains it.
   always_comb begin
      own_ready = owner_q ? rsp1_ready_ip : rsp0_ready_ip;
      slot_free = (state_q == ARB_IDLE) || own_ready;
      grant     = 1'b0;
      gnt_id    = 1'b0;
      if (slot_free && !reset) begin
         unique case ({req1_valid_ip, req0_valid_ip})
            2'b01: begin
               grant  = 1'b1;
               gnt_id = 1'b0;
            end
            2'b10: begin
               grant  = 1'b1;
               gnt_id = 1'b1;
            end
            2'b11: begin
               grant  = 1'b1;
               gnt_id = FIXED_PRIO ? 1'b0 : prio_q;
            end
            default: begin
               grant  = 1'b0;
               gnt_id = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (grant) begin
         state_d = ARB_HOLD;
      end else if (state_q == ARB_HOLD && own_ready) begin
         state_d = ARB_IDLE;
      end
   end

   always_comb begin
      req0_ready_op    = grant && !gnt_id;
      req1_ready_op    = grant && gnt_id;
      alu_enable_op    = grant;
      alu_operator_op  = ALU_ADD;
      alu_operand_a_op = '0;
      alu_operand_b_op = '0;
      if (grant) begin
         if (gnt_id) begin
            alu_operator_op  = req1_operator_ip;
            alu_operand_a_op = req1_operand_a_ip;
            alu_operand_b_op = req1_operand_b_ip;
         end else begin
            alu_operator_op  = req0_operator_ip;
            alu_operand_a_op = req0_operand_a_ip;
            alu_operand_b_op = req0_operand_b_ip;
         end
      end
      rsp0_valid_op = (state_q == ARB_HOLD) && !owner_q;
      rsp1_valid_op = (state_q == ARB_HOLD) && owner_q;
      rsp_result_op = result_q;
      rsp_error_op  = error_q;
   end

   // Result/error keep their value after the slot drains.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
         error_q  <= 1'b0;
         owner_q  <= 1'b0;
         prio_q   <= 1'b0;
      end else if (grant) begin
         result_q <= alu_result_ip;
         error_q  <= ~alu_valid_ip;
         owner_q  <= gnt_id;
         prio_q   <= ~gnt_id;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, scoreboard on the response
// ports, and directed contention/backpressure/reset sequences.
module tb_alu_arbiter;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid_ip = 1'b0;
   logic        req1_valid_ip = 1'b0;
   alu_opcode_e req0_operator_ip = ALU_ADD;
   alu_opcode_e req1_operator_ip = ALU_ADD;
   logic [31:0] req0_operand_a_ip = '0;
   logic [31:0] req0_operand_b_ip = '0;
   logic [31:0] req1_operand_a_ip = '0;
   logic [31:0] req1_operand_b_ip = '0;
   logic        rsp0_ready_ip = 1'b1;
   logic        rsp1_ready_ip = 1'b1;

   logic        req0_ready_op, req1_ready_op;
   logic        rsp0_valid_op, rsp1_valid_op;
   logic [31:0] rsp_result_op;
   logic        rsp_error_op;
   logic        alu_enable_op;
   alu_opcode_e alu_operator_op;
   logic [31:0] alu_operand_a_op, alu_operand_b_op;
   logic [31:0] alu_r;
   logic        alu_v;

   logic        f_req0_ready, f_req1_ready;
   logic        f_rsp0_valid, f_rsp1_valid;
   logic [31:0] f_result;
   logic        f_error;
   logic        f_alu_en;
   alu_opcode_e f_alu_op;
   logic [31:0] f_alu_a, f_alu_b;
   logic [31:0] f_alu_r;
   logic        f_alu_v;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   function automatic logic [32:0] alu_f(alu_opcode_e op,
                                        logic [31:0] a,
                                        logic [31:0] b);
      logic [31:0] r;
      logic        v;
      v = 1'b1;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_SLL:  r = a << b[4:0];
         ALU_SRL:  r = a >> b[4:0];
         ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
         ALU_SLTS: r = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: r = {31'd0, a < b};
         default: begin
            r = '0;
            v = 1'b0;
         end
      endcase
      return {v, r};
   endfunction

   always_comb {alu_v, alu_r} = alu_f(alu_operator_op,
                                      alu_operand_a_op,
                                      alu_operand_b_op);
   always_comb {f_alu_v, f_alu_r} = alu_f(f_alu_op, f_alu_a, f_alu_b);

   alu_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
      .clk(clk), .reset(reset),
      .req0_valid_ip(req0_valid_ip), .req0_ready_op(req0_ready_op),
      .req0_operator_ip(req0_operator_ip),
      .req0_operand_a_ip(req0_operand_a_ip),
      .req0_operand_b_ip(req0_operand_b_ip),
      .req1_valid_ip(req1_valid_ip), .req1_ready_op(req1_ready_op),
      .req1_operator_ip(req1_operator_ip),
      .req1_operand_a_ip(req1_operand_a_ip),
      .req1_operand_b_ip(req1_operand_b_ip),
      .rsp0_valid_op(rsp0_valid_op), .rsp0_ready_ip(rsp0_ready_ip),
      .rsp1_valid_op(rsp1_valid_op), .rsp1_ready_ip(rsp1_ready_ip),
      .rsp_result_op(rsp_result_op), .rsp_error_op(rsp_error_op),
      .alu_enable_op(alu_enable_op), .alu_operator_op(alu_operator_op),
      .alu_operand_a_op(alu_operand_a_op),
      .alu_operand_b_op(alu_operand_b_op),
      .alu_result_ip(alu_r), .alu_valid_ip(alu_v)
   );

   alu_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
      .clk(clk), .reset(reset),
      .req0_valid_ip(req0_valid_ip), .req0_ready_op(f_req0_ready),
      .req0_operator_ip(req0_operator_ip),
      .req0_operand_a_ip(req0_operand_a_ip),
      .req0_operand_b_ip(req0_operand_b_ip),
      .req1_valid_ip(req1_valid_ip), .req1_ready_op(f_req1_ready),
      .req1_operator_ip(req1_operator_ip),
      .req1_operand_a_ip(req1_operand_a_ip),
      .req1_operand_b_ip(req1_operand_b_ip),
      .rsp0_valid_op(f_rsp0_valid), .rsp0_ready_ip(rsp0_ready_ip),
      .rsp1_valid_op(f_rsp1_valid), .rsp1_ready_ip(rsp1_ready_ip),
      .rsp_result_op(f_result), .rsp_error_op(f_error),
      .alu_enable_op(f_alu_en), .alu_operator_op(f_alu_op),
      .alu_operand_a_op(f_alu_a), .alu_operand_b_op(f_alu_b),
      .alu_result_ip(f_alu_r), .alu_valid_ip(f_alu_v)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        own;
      logic [31:0] res;
      logic        err;
   } sb_t;

   sb_t sb[$];

   task automatic sb_push(logic own, alu_opcode_e op,
                          logic [31:0] a, logic [31:0] b);
      sb_t e;
      logic [32:0] vr;
      vr = alu_f(op, a, b);
      e.own = own;
      e.res = vr[31:0];
      e.err = ~vr[32];
      sb.push_back(e);
   endtask

   task automatic sb_pop(logic own);
      sb_t e;
      if (sb.size() == 0) begin
         chk("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("sb_owner", {31'd0, own}, {31'd0, e.own});
         chk("sb_result", rsp_result_op, e.res);
         chk("sb_error", {31'd0, rsp_error_op}, {31'd0, e.err});
      end
   endtask

   // Consumption is handled before new grants in the same cycle.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
      end else begin
         chk("ready_excl", {31'd0, req0_ready_op & req1_ready_op}, 32'd0);
         if (rsp0_valid_op && rsp0_ready_ip) sb_pop(1'b0);
         if (rsp1_valid_op && rsp1_ready_ip) sb_pop(1'b1);
         if (req0_ready_op)
            sb_push(1'b0, req0_operator_ip,
                    req0_operand_a_ip, req0_operand_b_ip);
         if (req1_ready_op)
            sb_push(1'b1, req1_operator_ip,
                    req1_operand_a_ip, req1_operand_b_ip);
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: timeout reached at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic set_req(int n, logic v, alu_opcode_e op,
                          logic [31:0] a, logic [31:0] b);
      if (n == 0) begin
         req0_valid_ip     = v;
         req0_operator_ip  = op;
         req0_operand_a_ip = a;
         req0_operand_b_ip = b;
      end else begin
         req1_valid_ip     = v;
         req1_operator_ip  = op;
         req1_operand_a_ip = a;
         req1_operand_b_ip = b;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      #4 reset = 1'b0;
   endtask

   typedef struct {
      logic        rq;
      alu_opcode_e op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        err;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs[NV];

   initial begin
      vecs[0] = '{1'b0, ALU_ADD,  32'd5,        32'd7, 32'd12,        1'b0};
      vecs[1] = '{1'b1, ALU_SUB,  32'd3,        32'd5, 32'hFFFFFFFE,  1'b0};
      vecs[2] = '{1'b1, ALU_SLTS, 32'hFFFFFFFF, 32'd1, 32'd1,         1'b0};
      vecs[3] = '{1'b0, ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0,         1'b0};
      vecs[4] = '{1'b0, ALU_XOR,  32'hF0F0F0F0, 32'hFF, 32'hF0F0F00F, 1'b0};
      vecs[5] = '{1'b1, ALU_SLL,  32'd1,        32'd31, 32'h80000000, 1'b0};
      vecs[6] = '{1'b0, ALU_SRA,  32'h80000000, 32'd4, 32'hF8000000,  1'b0};
      vecs[7] = '{1'b1, ALU_MUL,  32'd6,        32'd7, 32'd0,         1'b1};
      vecs[8] = '{1'b0, ALU_AND,  32'h0000FFFF, 32'h00FF00FF, 32'hFF, 1'b0};

      // Reset state, with a request pending during reset
      req0_valid_ip = 1'b1;
      #3;
      chk("rst_rsp0_valid", {31'd0, rsp0_valid_op}, 32'd0);
      chk("rst_rsp1_valid", {31'd0, rsp1_valid_op}, 32'd0);
      chk("rst_result", rsp_result_op, 32'd0);
      chk("rst_error", {31'd0, rsp_error_op}, 32'd0);
      chk("rst_req0_ready", {31'd0, req0_ready_op}, 32'd0);
      chk("rst_alu_en", {31'd0, alu_enable_op}, 32'd0);
      chk("rst_fp_valid", {31'd0, f_rsp0_valid | f_rsp1_valid}, 32'd0);
      chk("rst_fp_result", f_result, 32'd0);
      req0_valid_ip = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;

      // Single-requester vectors
      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1;
         rsp0_ready_ip = 1'b1;
         rsp1_ready_ip = 1'b1;
         set_req(int'(vecs[i].rq), 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
         #2;
         chk("v_grant", {31'd0, vecs[i].rq ? req1_ready_op : req0_ready_op}, 32'd1);
         chk("v_other", {31'd0, vecs[i].rq ? req0_ready_op : req1_ready_op}, 32'd0);
         chk("v_alu_en", {31'd0, alu_enable_op}, 32'd1);
         chk("v_alu_op", {28'd0, alu_operator_op}, {28'd0, vecs[i].op});
         chk("v_alu_a", alu_operand_a_op, vecs[i].a);
         chk("v_alu_b", alu_operand_b_op, vecs[i].b);
         @(posedge clk);
         #1;
         set_req(int'(vecs[i].rq), 1'b0, ALU_ADD, 32'd0, 32'd0);
         #2;
         chk("v_rsp_valid", {31'd0, vecs[i].rq ? rsp1_valid_op : rsp0_valid_op}, 32'd1);
         chk("v_rsp_other", {31'd0, vecs[i].rq ? rsp0_valid_op : rsp1_valid_op}, 32'd0);
         chk("v_result", rsp_result_op, vecs[i].res);
         chk("v_error", {31'd0, rsp_error_op}, {31'd0, vecs[i].err});
         @(posedge clk);
         #3;
         chk("v_idle_valid", {31'd0, rsp0_valid_op | rsp1_valid_op}, 32'd0);
         chk("v_idle_alu_en", {31'd0, alu_enable_op}, 32'd0);
         chk("v_idle_alu_op", {28'd0, alu_operator_op}, {28'd0, ALU_ADD});
         chk("v_idle_alu_a", alu_operand_a_op, 32'd0);
      end

      // Contention under round robin: 0,1,0,1
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
         set_req(1, 1'b1, ALU_SLTS, 32'hFFFFFFFF, 32'd1);
         #2;
         chk("rr_req0", {31'd0, req0_ready_op}, {31'd0, i % 2 == 0});
         chk("rr_req1", {31'd0, req1_ready_op}, {31'd0, i % 2 == 1});
         if (i > 0) begin
            chk("rr_prev_valid",
                {31'd0, (i % 2 == 1) ? rsp0_valid_op : rsp1_valid_op}, 32'd1);
            chk("rr_prev_result", rsp_result_op,
                (i % 2 == 1) ? 32'd3 : 32'd1);
         end
      end
      @(posedge clk);
      #1;
      set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
      set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
      #2;
      chk("rr_last_valid", {31'd0, rsp1_valid_op}, 32'd1);
      chk("rr_last_result", rsp_result_op, 32'd1);

      // Backpressure on requester 1, then owner drains with new grant
      @(posedge clk);
      #1;
      rsp1_ready_ip = 1'b0;
      rsp0_ready_ip = 1'b1;
      set_req(1, 1'b1, ALU_SUB, 32'd3, 32'd5);
      #2;
      chk("bp_grant", {31'd0, req1_ready_op}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
         set_req(0, 1'b1, ALU_ADD, 32'd9, 32'd9);
         #2;
         chk("bp_valid", {31'd0, rsp1_valid_op}, 32'd1);
         chk("bp_result", rsp_result_op, 32'hFFFFFFFE);
         chk("bp_no_grant", {31'd0, req0_ready_op}, 32'd0);
         chk("bp_alu_en", {31'd0, alu_enable_op}, 32'd0);
      end
      @(posedge clk);
      #1;
      rsp1_ready_ip = 1'b1;
      #2;
      chk("bp_drain_valid", {31'd0, rsp1_valid_op}, 32'd1);
      chk("bp_b2b_grant", {31'd0, req0_ready_op}, 32'd1);
      @(posedge clk);
      #1;
      set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
      #2;
      chk("b2b_rsp0", {31'd0, rsp0_valid_op}, 32'd1);
      chk("b2b_rsp1", {31'd0, rsp1_valid_op}, 32'd0);
      chk("b2b_result", rsp_result_op, 32'd18);
      @(posedge clk);
      #3;
      chk("drain_idle", {31'd0, rsp0_valid_op | rsp1_valid_op}, 32'd0);
      chk("drain_retain", rsp_result_op, 32'd18);

      // Asynchronous reset while holding a result
      @(posedge clk);
      #1;
      rsp0_ready_ip = 1'b0;
      set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
      @(posedge clk);
      #1;
      set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
      #2;
      chk("ar_hold_valid", {31'd0, rsp0_valid_op}, 32'd1);
      chk("ar_hold_result", rsp_result_op, 32'd12);
      reset = 1'b1;
      #1;
      chk("ar_valid", {31'd0, rsp0_valid_op | rsp1_valid_op}, 32'd0);
      chk("ar_result", rsp_result_op, 32'd0);
      chk("ar_error", {31'd0, rsp_error_op}, 32'd0);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      rsp0_ready_ip = 1'b1;
      rsp1_ready_ip = 1'b1;
      set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
      set_req(1, 1'b1, ALU_ADD, 32'd2, 32'd2);
      #2;
      chk("ar_no_stale", {31'd0, rsp0_valid_op}, 32'd0);
      chk("ar_ptr_req0", {31'd0, req0_ready_op}, 32'd1);
      chk("ar_ptr_req1", {31'd0, req1_ready_op}, 32'd0);
      @(posedge clk);
      #1;
      set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
      #2;
      chk("ar_next_req1", {31'd0, req1_ready_op}, 32'd1);
      chk("ar_rsp_result", rsp_result_op, 32'd2);
      @(posedge clk);
      #1;
      set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
      #2;
      chk("ar_rsp1_result", rsp_result_op, 32'd4);

      // Fixed priority: requester 0 always wins
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         set_req(0, 1'b1, ALU_OR, 32'h10, 32'h01);
         set_req(1, 1'b1, ALU_SRL, 32'h80, 32'd3);
         #2;
         chk("fp_req0", {31'd0, f_req0_ready}, 32'd1);
         chk("fp_req1", {31'd0, f_req1_ready}, 32'd0);
         chk("fp_alu_en", {31'd0, f_alu_en}, 32'd1);
         if (i > 0) begin
            chk("fp_rsp0", {31'd0, f_rsp0_valid & ~f_rsp1_valid}, 32'd1);
            chk("fp_result", f_result, 32'h11);
            chk("fp_error", {31'd0, f_error}, 32'd0);
         end
      end
      @(posedge clk);
      #1;
      set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
      set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #3;
      chk("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
